ram_param: RTL and testbench

Parametrised synchronous RAM that succeeds the fixed 16x8 bus RAM in the SAP-style datapath. Width and depth are parameters, and the data ports are split into din and a registered dout with a valid strobe. On reset the block sweeps every location to zero under a small state machine and reports busy until the sweep ends. Optional per-word parity reports storage corruption on read.

---
 rtl/ram_param.sv | 105 ++++++++++
 tb/tb_ram_param.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_param.sv
// rtl/ram_param.sv - parametrised synchronous RAM with reset clear sweep and registered read port
// Optional per-word even parity with error injection is enabled by defining RAM_PARITY_EN.
module ram_param #(
  parameter int WIDTH  = 8,
  parameter int AWIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              wa,
  input  logic              oa,
  input  logic [AWIDTH-1:0] addr,
  input  logic [WIDTH-1:0]  din,
  output logic [WIDTH-1:0]  dout,
  output logic              dvalid,
`ifdef RAM_PARITY_EN
  output logic              perr,
  input  logic              pinj,
`endif
  output logic              busy
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);

  localparam logic S_CLEAR = 1'b0;
  localparam logic S_IDLE  = 1'b1;

  logic              r_state;
  logic [AWIDTH-1:0] r_ptr;
  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [WIDTH-1:0]  r_dout;
  logic              r_dvalid;
  logic              r_busy;

  logic              w_clearing;
  logic              w_mem_we;
  logic [AWIDTH-1:0] w_mem_addr;
  logic [WIDTH-1:0]  w_mem_wdata;

  // The sweep owns the write port while clearing; user commands only reach it in IDLE.
  assign w_clearing  = (r_state == S_CLEAR);
  assign w_mem_we    = !rst && (w_clearing || (cs && wa));
  assign w_mem_addr  = w_clearing ? r_ptr : addr;
  assign w_mem_wdata = w_clearing ? '0 : din;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

`ifdef RAM_PARITY_EN
  logic [DEPTH-1:0] r_par;
  logic             r_perr;
  logic             w_par_wdata;
  logic             w_rd_par_err;

  assign w_par_wdata  = w_clearing ? 1'b0 : ((^din) ^ pinj);
  assign w_rd_par_err = r_par[addr] ^ (^r_mem[addr]);

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_par[w_mem_addr] <= w_par_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_clearing) begin
      r_perr <= 1'b0;
    end else begin
      r_perr <= cs && oa && !wa && w_rd_par_err;
    end
  end

  assign perr = r_perr;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_CLEAR;
      r_ptr    <= '0;
      r_dout   <= '0;
      r_dvalid <= 1'b0;
      r_busy   <= 1'b1;
    end else if (r_state == S_CLEAR) begin
      r_ptr    <= r_ptr + 1'b1;
      r_dvalid <= 1'b0;
      if (r_ptr == LAST_ADDR) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end
    end else begin
      r_dvalid <= cs && oa;
      if (cs && oa) begin
        r_dout <= wa ? din : r_mem[addr];
      end
    end
  end

  assign dout   = r_dout;
  assign dvalid = r_dvalid;
  assign busy   = r_busy;

endmodule

// File: tb/tb_ram_param.sv
// tb/tb_ram_param.sv - self-checking bench for ram_param (vector table, directed sequences, random vs model)
module tb_ram_param;

  logic       clk;
  logic       rst;
  logic       cs;
  logic       wa;
  logic       oa;
  logic [3:0] addr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       dvalid;
  logic       busy;
`ifdef RAM_PARITY_EN
  logic       perr;
  logic       pinj;
`endif

  ram_param #(.WIDTH(8), .AWIDTH(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .cs     (cs),
    .wa     (wa),
    .oa     (oa),
    .addr   (addr),
    .din    (din),
    .dout   (dout),
    .dvalid (dvalid),
`ifdef RAM_PARITY_EN
    .perr   (perr),
    .pinj   (pinj),
`endif
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: memory image, corrupted-word flags, remaining sweep edges.
  logic [7:0] m_mem [16];
  bit         m_bad [16];
  int         m_left = 0;
  logic       m_busy = 1'b1;
  logic       m_dvalid = 1'b0;
  logic       m_perr = 1'b0;
  logic [7:0] m_dout = 8'h00;

  typedef struct {
    logic       cs;
    logic       wa;
    logic       oa;
    logic [3:0] addr;
    logic [7:0] din;
    logic       exp_dvalid;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic c, input logic w, input logic o,
                            input logic [3:0] a, input logic [7:0] d, input logic pj);
    if (r) begin
      m_left = 16; m_busy = 1'b1; m_dout = 8'h00; m_dvalid = 1'b0; m_perr = 1'b0;
    end else if (m_left > 0) begin
      m_mem[16 - m_left] = 8'h00;
      m_bad[16 - m_left] = 1'b0;
      m_left--;
      m_busy = (m_left != 0);
      m_dvalid = 1'b0; m_perr = 1'b0;
    end else begin
      m_dvalid = c && o;
      m_perr = 1'b0;
      if (c && o && !w) begin
        m_dout = m_mem[a];
        m_perr = m_bad[a];
      end
      if (c && o && w) m_dout = d;
      if (c && w) begin
        m_mem[a] = d;
        m_bad[a] = pj;
      end
    end
  endtask

  task automatic run_cycle(input logic r, input logic c, input logic w, input logic o,
                           input logic [3:0] a, input logic [7:0] d, input logic pj);
    rst = r; cs = c; wa = w; oa = o; addr = a; din = d;
`ifdef RAM_PARITY_EN
    pinj = pj;
`endif
    @(posedge clk);
    model_edge(r, c, w, o, a, d, pj);
    #1;
    check("model_dvalid", {31'd0, dvalid}, {31'd0, m_dvalid});
    check("model_busy", {31'd0, busy}, {31'd0, m_busy});
    check("model_dout", {24'd0, dout}, {24'd0, m_dout});
`ifdef RAM_PARITY_EN
    check("model_perr", {31'd0, perr}, {31'd0, m_perr});
`endif
  endtask

  task automatic idle_cycle();
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
  endtask

  // Counts samples with busy high, starting with the sample after the last reset edge.
  task automatic wait_idle(output int n);
    n = busy ? 1 : 0;
    for (int i = 0; i < 100 && busy; i++) begin
      idle_cycle();
      if (busy) n++;
    end
    check("sweep_timeout", {31'd0, busy}, 32'd0);
  endtask

  int n;

  initial begin
    rst = 1'b1; cs = 1'b0; wa = 1'b0; oa = 1'b0; addr = 4'd0; din = 8'h00;
`ifdef RAM_PARITY_EN
    pinj = 1'b0;
`endif
    #2;

    // Reset state and sweep length
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    check("reset_dout", {24'd0, dout}, 32'h0);
    check("reset_dvalid", {31'd0, dvalid}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd1);
    wait_idle(n);
    check("sweep_len_first", n, 32'd16);

    // Preload all-ones, then a reset must clear every word
    for (int a = 0; a < 16; a++) run_cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'(a), 8'hFF, 1'b0);
    run_cycle(1'b0, 1'b1, 1'b0, 1'b1, 4'd9, 8'h00, 1'b0);
    check("preload_rd", {24'd0, dout}, 32'hFF);
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    wait_idle(n);
    check("sweep_len_preload", n, 32'd16);
    for (int a = 0; a < 16; a++) begin
      run_cycle(1'b0, 1'b1, 1'b0, 1'b1, 4'(a), 8'h00, 1'b0);
      check("clear_rd_dout", {24'd0, dout}, 32'h0);
      check("clear_rd_dvalid", {31'd0, dvalid}, 32'd1);
    end

    // Vector table: writes, back-to-back reads, write-through, cs=0 write, hold
    for (int i = 0; i < 8; i++) vecs.push_back('{1'b1, 1'b1, 1'b0, 4'(i), 8'(i), 1'b0, 8'h00});
    for (int i = 0; i < 8; i++) vecs.push_back('{1'b1, 1'b0, 1'b1, 4'(i), 8'hEE, 1'b1, 8'(i)});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 4'd3, 8'hA5, 1'b1, 8'hA5});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 4'd2, 8'h5A, 1'b0, 8'hA5});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 4'd6, 8'h33, 1'b0, 8'hA5});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 4'd3, 8'h00, 1'b1, 8'hA5});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 4'd2, 8'h00, 1'b1, 8'h02});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 4'd6, 8'h00, 1'b1, 8'h06});
    foreach (vecs[i]) begin
      run_cycle(1'b0, vecs[i].cs, vecs[i].wa, vecs[i].oa, vecs[i].addr, vecs[i].din, 1'b0);
      check($sformatf("vec%0d_dvalid", i), {31'd0, dvalid}, {31'd0, vecs[i].exp_dvalid});
      check($sformatf("vec%0d_dout", i), {24'd0, dout}, {24'd0, vecs[i].exp_dout});
    end

    // Writes during the late sweep and with cs=0 are ignored
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    for (int i = 0; i < 9; i++) idle_cycle();
    for (int i = 0; i < 5; i++) run_cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'd2, 8'h5A, 1'b0);
    check("busy_late_sweep", {31'd0, busy}, 32'd1);
    wait_idle(n);
    run_cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 8'h5A, 1'b0);
    run_cycle(1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 8'h00, 1'b0);
    check("ignore_rd_dout", {24'd0, dout}, 32'h0);
    check("ignore_rd_dvalid", {31'd0, dvalid}, 32'd1);

    // Reset during a read, then reset again mid-sweep
    run_cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 8'h77, 1'b0);
    run_cycle(1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 8'h00, 1'b0);
    check("pre_rst_dout", {24'd0, dout}, 32'h77);
    run_cycle(1'b1, 1'b1, 1'b0, 1'b1, 4'd1, 8'h00, 1'b0);
    check("rst_rd_dvalid", {31'd0, dvalid}, 32'd0);
    check("rst_rd_dout", {24'd0, dout}, 32'h0);
    for (int i = 0; i < 7; i++) idle_cycle();
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    check("mid_rst_dout", {24'd0, dout}, 32'h0);
    check("mid_rst_dvalid", {31'd0, dvalid}, 32'd0);
    wait_idle(n);
    check("sweep_len_mid", n, 32'd16);

`ifdef RAM_PARITY_EN
    run_cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'd4, 8'h01, 1'b1);
    run_cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'd5, 8'h03, 1'b0);
    run_cycle(1'b0, 1'b1, 1'b0, 1'b1, 4'd4, 8'h00, 1'b0);
    check("par4_perr", {31'd0, perr}, 32'd1);
    check("par4_dvalid", {31'd0, dvalid}, 32'd1);
    run_cycle(1'b0, 1'b1, 1'b0, 1'b1, 4'd5, 8'h00, 1'b0);
    check("par5_perr", {31'd0, perr}, 32'd0);
    check("par5_dvalid", {31'd0, dvalid}, 32'd1);
    run_cycle(1'b0, 1'b1, 1'b1, 1'b1, 4'd7, 8'h0F, 1'b1);
    check("par_wt_perr", {31'd0, perr}, 32'd0);
`endif

    // Random traffic against the model, with occasional resets
    for (int i = 0; i < 600; i++) begin
      run_cycle($urandom_range(0, 63) == 0, 1'($urandom), 1'($urandom), 1'($urandom),
                4'($urandom), 8'($urandom), $urandom_range(0, 7) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
